ctrl_trace_capture: RTL
=======================

// Module: ctrl_trace_capture
// PURPOSE
// - Passive observer on the generated control unit's bus: samples the FSM state register and the packed
//   control-signal vector (outSignals: ld/sel bits) every clk, starting at a programmable trigger.
// - Buffers the samples in a DEPTH-entry FIFO and drains them over a valid/ready read port to a host/bench.
// - Reader side of the control bus the FSM drives; never drives datapath signals.
// PARAMETERS
// - STATE_W  2   width of observed state register
// - SIG_W    2   width of observed control-signal vector
// - DEPTH    16  FIFO entries; power of 2, >= 2
// - CNT_W    5   width of count output; must be >= log2(DEPTH)+1
// PORTS
// - clk         in   1              single clock; all sampling on posedge
// - rst_n       in   1              asynchronous, active-low reset
// - state_in    in   STATE_W        observed FSM state
// - sig_in      in   SIG_W          observed control vector
// - arm         in   1              1-cycle pulse: flush FIFO, enter ARMED
// - trig_en     in   1              1: wait for trig_state; 0: trigger on first ARMED cycle
// - trig_state  in   STATE_W        trigger state value
// - rd_valid    out  1              FIFO non-empty
// - rd_ready    in   1              host accepts rd_data
// - rd_data     out  STATE_W+SIG_W  {state, sig} of oldest entry
// - count       out  CNT_W          entries currently held (0..DEPTH)
// - busy        out  1              in ARMED or CAPTURE
// - done        out  1              capture finished (DONE state)
// BEHAVIOUR
// - Reset (rst_n=0, async): state IDLE, FIFO empty, rd_valid=0, rd_data=0, count=0, busy=0, done=0, cap_cnt=0.
// - FSM: IDLE -arm-> ARMED; ARMED -trigger-> CAPTURE; CAPTURE -cap_cnt==DEPTH-> DONE; DONE -arm-> ARMED.
// - arm in any state: flush FIFO (count=0, rd_valid=0 next cycle), clear cap_cnt, go ARMED; arm wins over
//   any same-cycle trigger, write, or pop.
// - Trigger: in ARMED, trig_en=0 or state_in==trig_state. The trigger cycle's sample is written as entry 0
//   in that same cycle; FSM is in CAPTURE next cycle.
// - CAPTURE: writes {state_in, sig_in} every cycle; cap_cnt increments per write.
// - Last write: the cycle cap_cnt reaches DEPTH; then DONE. Exactly DEPTH samples captured per arm.
// - Write is blocked while count==DEPTH, regardless of cap_cnt.
// - Blocked write: sample dropped, cap_cnt not incremented. Capture ends only after DEPTH stored entries.
// - Read: first-word-fall-through. rd_valid = (count != 0); rd_data = oldest entry, combinational from
//   the read pointer. Pop on rd_valid & rd_ready.
// - Read/write latency: an entry written at edge t is visible (rd_valid=1) after edge t.
// - Pop and write in the same cycle: both happen; count unchanged.
// - rd_ready with rd_valid=0: no effect.
// - Reads allowed in every state, including IDLE and DONE.
// - Pointers: ADDR_W=log2(DEPTH) bits, wrap modulo DEPTH. count is updated +1/-1/0 per cycle.
// - rst_n asserted mid-capture: immediate return to reset values; captured data discarded.
// - busy = state in {ARMED, CAPTURE}; done = state==DONE. Both are registered state decodes.
// CONFIGURATION
// - CTRL_TRACE_COMPRESS_EN defined: in CAPTURE, write only when {state_in, sig_in} differs from the last
//   written entry. The trigger sample is always written. cap_cnt counts written entries only, so DONE
//   needs DEPTH distinct transitions.
// - CTRL_TRACE_COMPRESS_EN undefined: every CAPTURE cycle writes, as above. Port list identical either way.
// TESTING
// - Reset: rst_n=0 mid-CAPTURE with count=5 -> rd_valid=0, count=0, busy=0, done=0 without waiting for clk.
// - Immediate trigger: trig_en=0, arm pulse, rd_ready=0, sig_in ramps 0,1,2,3...
//   -> DEPTH=16 entries 0..15 in order; done=1 after entry 15; count=16.
// - State trigger: trig_en=1, trig_state=2, state_in sequence 0,1,0,2,0,...
//   -> first rd_data has state field 2; busy=1 from arm until DONE.
// - Full/backpressure: rd_ready=0 until count=16 -> no further writes.
//   Then rd_ready=1 for 16 cycles -> entries drain in order, count=0, rd_valid=0.
// - Concurrent pop+write: rd_ready=1 throughout CAPTURE -> count stays 1 after the first write.
//   done asserts after 16 writes; host sees all 16 samples.
// - Re-arm in DONE with count=7 -> next cycle count=0, rd_valid=0, busy=1.
//   [COMPRESS_EN] constant input for 20 cycles -> exactly 1 entry, done=0.

Source files
------------

// File: rtl/ctrl_trace_capture.sv
// ============================================================================
// Module : ctrl_trace_capture
// Brief  : Passive control-bus tracer; captures DEPTH {state, sig} samples from a
//          trigger point into a first-word-fall-through FIFO. Optional build macro
//          CTRL_TRACE_COMPRESS_EN stores only samples that differ from the last one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_trace_capture #(
  parameter int STATE_W = 2,
  parameter int SIG_W   = 2,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [STATE_W-1:0]         state_in,
  input  logic [SIG_W-1:0]           sig_in,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [STATE_W-1:0]         trig_state,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [STATE_W+SIG_W-1:0]   rd_data,
  output logic [CNT_W-1:0]           count,
  output logic                       busy,
  output logic                       done
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DATA_W = STATE_W + SIG_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        fsm;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cap_cnt;

  logic [DATA_W-1:0] sample;
  logic              full;
  logic              trigger;
  logic              changed;
  logic              wr_en;
  logic              pop;
  logic              last_write;

  assign sample  = {state_in, sig_in};
  assign full    = (cnt == CNT_W'(DEPTH));
  assign trigger = (fsm == S_ARMED) && (!trig_en || (state_in == trig_state));

`ifdef CTRL_TRACE_COMPRESS_EN
  logic [DATA_W-1:0] last_wr;
  assign changed = (sample != last_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= '0;
    end else if (wr_en) begin
      last_wr <= sample;
    end
  end
`else
  assign changed = 1'b1;
`endif

  // arm overrides every same-cycle write and pop
  assign wr_en      = !arm && !full && (trigger || ((fsm == S_CAPTURE) && changed));
  assign pop        = !arm && rd_valid && rd_ready;
  assign last_write = wr_en && (fsm == S_CAPTURE) && (cap_cnt == CNT_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      cap_cnt <= '0;
    end else if (arm) begin
      fsm     <= S_ARMED;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      cap_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr  <= wr_ptr + ADDR_W'(1);
        cap_cnt <= cap_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (trigger && wr_en) begin
        fsm <= S_CAPTURE;
      end else if (last_write) begin
        fsm <= S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample;
    end
  end

  assign rd_valid = (cnt != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign count    = cnt;
  assign busy     = (fsm == S_ARMED) || (fsm == S_CAPTURE);
  assign done     = (fsm == S_DONE);

endmodule

`default_nettype wire
